// File: rtl/input_buffer_ctrl.sv
// input_buffer_ctrl: loads one frame into the input buffer, then streams it back out in address order
module input_buffer_ctrl #(
    parameter int CTRL_DATA_WIDTH = 8,
    parameter int CTRL_ADDR_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CTRL_ADDR_WIDTH:0]   frame_len,
    input  logic                       s_valid,
    input  logic [CTRL_DATA_WIDTH-1:0] s_data,
    output logic                       s_ready,
    output logic                       buf_wr_en,
    output logic [CTRL_ADDR_WIDTH-1:0] buf_wr_addr,
    output logic [CTRL_DATA_WIDTH-1:0] buf_wr_data,
    output logic                       buf_rd_en,
    output logic [CTRL_ADDR_WIDTH-1:0] buf_rd_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] buf_rd_data,
    output logic                       m_valid,
    output logic [CTRL_DATA_WIDTH-1:0] m_data,
    output logic                       m_last,
    input  logic                       m_ready,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam logic [CTRL_ADDR_WIDTH:0] DEPTH = {1'b1, {CTRL_ADDR_WIDTH{1'b0}}};
    localparam logic [CTRL_ADDR_WIDTH:0] ONE = {{CTRL_ADDR_WIDTH{1'b0}}, 1'b1};
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
    state_t state_q, state_d;
    logic [CTRL_ADDR_WIDTH:0] len_q, len_d, wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic inflight_q, inflight_d, rd_last_q, rd_last_d, err_q, err_d;
    logic [1:0] count_q, count_d;
    logic [CTRL_DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
    logic last0_q, last0_d, last1_q, last1_d;
    logic start_ok, wr_fire, pop, push, issue, push_lo, push_hi;
    // Handshakes, read-issue throttle and the externally visible outputs
    always_comb begin
        start_ok = start && frame_len != '0 && frame_len <= DEPTH;
        wr_fire = state_q == LOAD && s_valid;
        pop = count_q != 2'd0 && m_ready;
        push = inflight_q;
        // a pop in this cycle frees the slot a new read will eventually land in
        issue = state_q == DRAIN && rd_cnt_q < len_q && (count_q + {1'b0, inflight_q} != 2'd2 || pop);
        s_ready = state_q == LOAD;
        buf_wr_en = wr_fire;
        buf_wr_addr = wr_fire ? wr_cnt_q[CTRL_ADDR_WIDTH-1:0] : '0;
        buf_wr_data = wr_fire ? s_data : '0;
        buf_rd_en = issue;
        buf_rd_addr = issue ? rd_cnt_q[CTRL_ADDR_WIDTH-1:0] : '0;
        m_valid = count_q != 2'd0;
        m_data = m_valid ? data0_q : '0;
        m_last = m_valid && last0_q;
        busy = state_q != IDLE;
        done = state_q == DONE;
        err = err_q;
    end
    // Frame sequencing and counter next-state
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        wr_cnt_d = wr_fire ? wr_cnt_q + ONE : wr_cnt_q;
        rd_cnt_d = issue ? rd_cnt_q + ONE : rd_cnt_q;
        inflight_d = issue;
        rd_last_d = issue && rd_cnt_q + ONE == len_q;
        err_d = state_q == IDLE && start && !start_ok;
        case (state_q)
            IDLE: if (start_ok) begin
                state_d = LOAD;
                len_d = frame_len;
                wr_cnt_d = '0;
                rd_cnt_d = '0;
            end
            LOAD: state_d = wr_fire && wr_cnt_q + ONE == len_q ? DRAIN : LOAD;
            DRAIN: state_d = pop && last0_q ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    // Two-entry output FIFO: entry 0 is the head, returning reads land in the first free slot
    always_comb begin
        push_lo = push && (count_q == 2'd0 || (count_q == 2'd1 && pop));
        push_hi = push && !push_lo;
        count_d = push && !pop ? count_q + 2'd1 : (!push && pop ? count_q - 2'd1 : count_q);
        data0_d = push_lo ? buf_rd_data : (pop ? data1_q : data0_q);
        last0_d = push_lo ? rd_last_q : (pop ? last1_q : last0_q);
        data1_d = push_hi ? buf_rd_data : data1_q;
        last1_d = push_hi ? rd_last_q : last1_q;
    end
    // State registers; reset drops any in-flight read and empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q <= '0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            inflight_q <= 1'b0;
            rd_last_q <= 1'b0;
            err_q <= 1'b0;
            count_q <= 2'd0;
            data0_q <= '0;
            data1_q <= '0;
            last0_q <= 1'b0;
            last1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            inflight_q <= inflight_d;
            rd_last_q <= rd_last_d;
            err_q <= err_d;
            count_q <= count_d;
            data0_q <= data0_d;
            data1_q <= data1_d;
            last0_q <= last0_d;
            last1_q <= last1_d;
        end
    end
endmodule

// File: tb/tb_input_buffer_ctrl.sv
// tb_input_buffer_ctrl: directed frames against a behavioural buffer with a registered read port
module tb_input_buffer_ctrl;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;
    logic clk = 1'b0;
    logic rst, start, s_valid, s_ready, buf_wr_en, buf_rd_en, m_valid, m_last, m_ready, busy, done, err;
    logic [AW:0] frame_len;
    logic [DW-1:0] s_data, buf_wr_data, buf_rd_data, m_data;
    logic [AW-1:0] buf_wr_addr, buf_rd_addr;
    logic [DW-1:0] mem [DEPTH];
    int n_tests = 0;
    int n_fail = 0;

    input_buffer_ctrl #(.CTRL_DATA_WIDTH(DW), .CTRL_ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .frame_len(frame_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Buffer model: write-through on wr_en, read data registered one cycle after rd_en
    always @(posedge clk) begin
        if (buf_wr_en) mem[buf_wr_addr] <= buf_wr_data;
        if (buf_rd_en) buf_rd_data <= mem[buf_rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_rst(input string tag);
        check(tag, {s_ready, buf_wr_en, buf_rd_en, m_valid, m_last, busy, done, err,
                    buf_wr_addr, buf_wr_data, buf_rd_addr, m_data}, 32'h0);
    endtask

    // One full frame: words base, base+1, ... ; optional upstream bubbles, downstream stalls, starts while busy
    task automatic run_frame(input int len, input logic [7:0] base, input bit bubbly, input bit bp, input bit bs);
        int t, i, k, nrd;
        frame_len = len[AW:0];
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("start_busy", {busy, s_ready}, 2'b11);
        i = 0;
        t = 0;
        while (i < len && t < 100) begin
            s_valid = bubbly ? (t % 2 == 0) : 1'b1;
            s_data = base + i[7:0];
            start = bs && t == 1;
            if (bs) frame_len = '0;
            #1;
            check("wr_en", buf_wr_en, s_valid);
            if (s_valid) begin
                check("wr_addr", buf_wr_addr, i);
                check("wr_data", buf_wr_data, s_data);
                i++;
            end
            if (bs) check("err_busy_load", err, 0);
            cycle();
            t++;
        end
        check("load_count", i, len);
        s_valid = 1'b0;
        start = 1'b0;
        t = 0;
        k = 0;
        nrd = 0;
        while (k < len && t < 200) begin
            m_ready = bp ? (t % 3 == 0) : 1'b1;
            start = bs && t == 1;
            #1;
            if (t == 0) check("drain_entry", {s_ready, buf_rd_en, m_valid}, 3'b010);
            if (!bp) check("m_valid_timing", m_valid, t >= 2);
            if (buf_rd_en) begin
                check("rd_addr", buf_rd_addr, nrd);
                nrd++;
            end
            if (m_valid) begin
                check("m_data", m_data, base + k[7:0]);
                check("m_last", m_last, k == len - 1);
            end
            if (bs) check("err_busy_drain", err, 0);
            if (m_valid && m_ready) k++;
            check("outstanding", (nrd - k) <= 2, 1);
            cycle();
            t++;
        end
        check("drain_count", k, len);
        check("read_count", nrd, len);
        m_ready = 1'b1;
        start = 1'b0;
        #1;
        check("done_pulse", {done, busy, m_valid, err}, 4'b1100);
        cycle();
        check("back_idle", {done, busy, s_ready, err}, 4'b0000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        frame_len = '0;
        s_valid = 1'b0;
        s_data = '0;
        m_ready = 1'b0;
        repeat (2) cycle();
        check_rst("reset_values");
        rst = 1'b0;
        cycle();
        check_rst("idle_after_reset");

        run_frame(4, 8'hA1, 1'b0, 1'b0, 1'b0);
        run_frame(8, 8'h10, 1'b0, 1'b1, 1'b0);
        run_frame(3, 8'h30, 1'b1, 1'b0, 1'b0);
        run_frame(1, 8'h55, 1'b0, 1'b0, 1'b0);
        run_frame(DEPTH, 8'h80, 1'b0, 1'b0, 1'b0);

        // Rejected starts: zero length and one past depth
        frame_len = 4'd0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("err_len0", {err, busy}, 2'b10);
        cycle();
        check("err_len0_clear", {err, busy}, 2'b00);
        frame_len = 4'd9;
        start = 1'b1;
        cycle();
        start = 1'b0;
        check("err_len9", {err, busy}, 2'b10);
        cycle();
        check("err_len9_clear", {err, busy}, 2'b00);

        run_frame(5, 8'h60, 1'b0, 1'b0, 1'b1);

        // Reset during LOAD after two of five words
        frame_len = 4'd5;
        start = 1'b1;
        cycle();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = 8'hE0;
        cycle();
        s_data = 8'hE1;
        cycle();
        s_valid = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_rst("rst_in_load");

        // Reset during DRAIN with a read in flight and the sink stalled
        frame_len = 4'd5;
        start = 1'b1;
        cycle();
        start = 1'b0;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_data = 8'hF0 + i[7:0];
            cycle();
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_rst("rst_in_drain");

        run_frame(2, 8'hC0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/input_buffer_ctrl.md
# input_buffer_ctrl

Sequencing controller for the input buffer. It accepts one frame of input words from an upstream valid/ready stream and writes them into the buffer at sequential addresses. Once the frame is loaded, it reads the words back in address order and streams them to the downstream compute stage, with full backpressure support. It sits between the input DMA/stream source and the MAC datapath, and it owns both buffer ports.

## Interface
Parameters:
- CTRL_DATA_WIDTH, default DATA_WIDTH: word width; must equal the buffer data width.
- CTRL_ADDR_WIDTH, default ADDR_WIDTH: buffer address width. Depth is 2^CTRL_ADDR_WIDTH.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  reset, synchronous, active-high. The top level drives the buffer's rst_n from ~rst.
- start  in  1  single-cycle request to begin a frame; sampled only in IDLE.
- frame_len  in  CTRL_ADDR_WIDTH+1  words per frame; latched on an accepted start.
- s_valid  in  1  upstream word valid.
- s_data  in  CTRL_DATA_WIDTH  upstream word.
- s_ready  out  1  controller accepts s_data.
- buf_wr_en  out  1  buffer write enable.
- buf_wr_addr  out  CTRL_ADDR_WIDTH  buffer write address.
- buf_wr_data  out  CTRL_DATA_WIDTH  buffer write data.
- buf_rd_en  out  1  buffer read enable.
- buf_rd_addr  out  CTRL_ADDR_WIDTH  buffer read address.
- buf_rd_data  in  CTRL_DATA_WIDTH  buffer read data; registered, valid the cycle after buf_rd_en.
- m_valid  out  1  downstream word valid.
- m_data  out  CTRL_DATA_WIDTH  downstream word.
- m_last  out  1  qualifies the final word of the frame.
- m_ready  in  1  downstream accepts m_data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  single-cycle pulse after the last word's handshake.
- err  out  1  single-cycle pulse when a start is rejected.

## Operation
- The controller has four states: IDLE, LOAD, DRAIN, DONE.
- IDLE: s_ready=0, no buffer accesses. On start with 1 ≤ frame_len ≤ 2^CTRL_ADDR_WIDTH:
  - latch len;
  - clear wr_cnt and rd_cnt;
  - go to LOAD.
- Invalid start (frame_len=0 or frame_len > depth): pulse err next cycle and stay in IDLE.
- start while busy is ignored; err is not raised.
- LOAD:
  - s_ready=1.
  - Each cycle with s_valid&&s_ready, the write is combinational pass-through: buf_wr_en=1, buf_wr_addr=wr_cnt, buf_wr_data=s_data.
  - wr_cnt increments on each accepted word.
  - On acceptance of word len-1, go to DRAIN. s_ready is 0 from that next cycle.
- DRAIN:
  - Reads are issued in address order, rd_cnt from 0 to len-1.
  - Returned data lands in a 2-entry output FIFO. m_valid, m_data and m_last come from the FIFO head.
  - A read may issue only if rd_cnt < len and (FIFO occupancy + read-in-flight) < 2, counting a pop in the same cycle as freeing a slot.
  - m_last is high on the word read from address len-1.
  - When the m_last word is handshaken, go to DONE.
- DONE: done=1 for one cycle, then go to IDLE.
- Width rule: all counters are CTRL_ADDR_WIDTH+1 bits. Addresses are the low CTRL_ADDR_WIDTH bits. A full-depth frame never wraps.
- Reset, including mid-frame:
  - state returns to IDLE; counters and FIFO are cleared;
  - any in-flight read is discarded;
  - buffer contents are not cleared.

## Timing
- Reset values: s_ready, buf_wr_en, buf_rd_en, m_valid, m_last, busy, done and err are 0. buf_wr_addr, buf_wr_data, buf_rd_addr and m_data are 0.
- start is accepted at edge E; busy and s_ready are high from E+1.
- LOAD throughput is 1 word/cycle.
- The first DRAIN cycle is T:
  - buf_rd_en=1 with addr 0 in cycle T;
  - buf_rd_data is valid in T+1 and is pushed into the FIFO at the end of T+1;
  - m_valid rises in T+2.
- With m_ready held high, m_valid stays high for len consecutive cycles.
- With m_ready low, at most 2 words are buffered and no read issues. m_data and m_last stay stable while m_valid&&!m_ready.
- done is pulsed in the cycle after the final handshake. The next start is accepted from the cycle after done.
- Minimum frame time with no stalls: 1 + len (LOAD) + len + 2 (DRAIN) + 1 (DONE) cycles.

## Test plan
- Basic frame: start, frame_len=4, words 0xA1..0xA4 with s_valid held high, m_ready=1.
  - Writes go to addresses 0..3.
  - Reads go to 0..3 and m_data is A1,A2,A3,A4 on consecutive cycles, starting 2 cycles after DRAIN entry.
  - m_last is high only on A4. done pulses once. busy falls with the return to IDLE.
- Backpressure: frame_len=8 and m_ready toggling 1,0,0,1,...
  - No word is lost or duplicated.
  - m_data is stable while stalled.
  - Never more than 2 reads are outstanding or buffered.
- Bubbly upstream: s_valid high on alternate cycles, frame_len=3.
  - wr_cnt advances only on handshakes.
  - The DRAIN output order is unchanged.
- Boundary:
  - frame_len=1 gives a single m_valid with m_last=1.
  - frame_len=depth fills addresses 0..depth-1 with no wrap.
  - frame_len=0 and frame_len=depth+1 each pulse err for 1 cycle, and busy stays 0.
- Reset mid-operation: assert rst for 1 cycle during LOAD (after 2 of 5 words) and again during DRAIN with m_ready=0.
  - All outputs return to their reset values the next cycle.
  - A subsequent frame_len=2 frame completes correctly.
- Start during busy: pulse start in LOAD and in DRAIN. It is ignored, err stays 0, and the current frame is unaffected.
